// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB slave register bank.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_slave_state_t;

  localparam int unsigned APB_WORD_BYTES = 4;

  // Word index of a byte address, masked to the register count.
  function automatic int unsigned word_index(
    input logic [63:0] addr,
    input int unsigned num_words
  );
    logic [63:0] w;
    w = addr >> 2;
    return 32'(w & 64'(num_words - 1));
  endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// Wait-state counter and registered PREADY for the APB slave.
module apb_wait_ctrl #(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  input  logic abort,
  output logic ready,
  output logic fire
);

  logic [3:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;

  always_comb begin
    cnt_d = cnt_q;
    rdy_d = rdy_q;
    if (abort) begin
      cnt_d = '0;
      rdy_d = 1'b0;
    end else if (load) begin
      cnt_d = 4'(WAIT_STATES);
      rdy_d = (WAIT_STATES == 0);
    end else if (tick) begin
      cnt_d = cnt_q - 4'd1;
      rdy_d = (cnt_q == 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  assign ready = rdy_q;
  // High on the edge where PREADY goes from 0 to 1.
  assign fire  = rdy_d & ~rdy_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank with configurable wait states.
// Define APB_SLAVE_PSLVERR_EN to report bad addresses on PSLVERR.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WORDS   = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(NUM_WORDS * APB_WORD_BYTES);

  apb_slave_state_t state_q, state_d;

  logic [IW-1:0]         idx_q;
  logic                  wr_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_WORDS];

  logic          load, tick, abort, complete;
  logic          ready, fire;
  logic [IW-1:0] dec_idx, rd_idx;
  logic          dec_ok, rd_ok, rd_wr;

  assign dec_idx = IW'(word_index(64'(PADDR), NUM_WORDS));
  assign dec_ok  = (PADDR[1:0] == 2'b00) && (PADDR < LIMIT);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    tick     = 1'b0;
    abort    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (PENABLE && !ready) begin
          tick = 1'b1;
        end else if (PENABLE && ready) begin
          abort    = 1'b1;
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  apb_wait_ctrl #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait (
    .clk  (PCLK),
    .rst  (PRESET),
    .load (load),
    .tick (tick),
    .abort(abort),
    .ready(ready),
    .fire (fire)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      vld_q   <= 1'b0;
      wdata_q <= '0;
    end else if (load) begin
      idx_q   <= dec_idx;
      wr_q    <= PWRITE;
      vld_q   <= dec_ok;
      wdata_q <= PWDATA;
    end
  end

  // With zero wait states the read fires on the setup edge itself.
  assign rd_idx = (state_q == IDLE) ? dec_idx : idx_q;
  assign rd_ok  = (state_q == IDLE) ? dec_ok  : vld_q;
  assign rd_wr  = (state_q == IDLE) ? PWRITE  : wr_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prdata_q <= '0;
    end else if (fire && !rd_wr) begin
      prdata_q <= rd_ok ? regs_q[rd_idx] : '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_WORDS; i++) regs_q[i] <= '0;
    end else if (complete && wr_q && vld_q) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

`ifdef APB_SLAVE_PSLVERR_EN
  logic err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)     err_q <= 1'b0;
    else if (abort) err_q <= 1'b0;
    else if (fire)  err_q <= !rd_ok;
  end

  assign PSLVERR = err_q;
`else
  assign PSLVERR = 1'b0;
`endif

  assign PRDATA = prdata_q;
  assign PREADY = ready;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank at WAIT_STATES 1, 0 and 3.
module tb_apb_slave_regbank;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        psel   [3];
  logic        pen    [3];
  logic        pwr    [3];
  logic [31:0] paddr  [3];
  logic [31:0] pwdata [3];
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr[3];

  logic [31:0] mem    [3][16];
  logic [31:0] last_rd[3];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_regbank #(.WAIT_STATES(1)) u_ws1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(pen[0]),
    .PADDR(paddr[0]), .PWRITE(pwr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_slave_regbank #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(pen[1]),
    .PADDR(paddr[1]), .PWRITE(pwr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_slave_regbank #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(pen[2]),
    .PADDR(paddr[2]), .PWRITE(pwr[2]), .PWDATA(pwdata[2]),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = '0;
      for (int i = 0; i < 16; i++) mem[d][i] = '0;
    end
  endtask

  task automatic setup(input int d, input logic [31:0] a,
                       input logic w, input logic [31:0] wd);
    @(negedge PCLK);
    psel[d] = 1'b1; pen[d] = 1'b0;
    paddr[d] = a; pwr[d] = w; pwdata[d] = wd;
    @(negedge PCLK);
    pen[d] = 1'b1;
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input string tag);
    exp_t e;
    bit   ok;
    int   waits;
    ok = (a[1:0] == 2'b00) && (a < 32'd64);
    e.err = ERR_EN && !ok;
    if (!w) begin
      e.data = ok ? mem[d][a[5:2]] : 32'd0;
      last_rd[d] = e.data;
    end else begin
      e.data = last_rd[d];
    end
    sb.push_back(e);
    setup(d, a, w, wd);
    waits = 0;
    while (pready[d] !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge PCLK);
    end
    if (pready[d] !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(pready[d]), 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, prdata[d], e.data);
      chk({tag, "_err"}, 32'(pslverr[d]), 32'(e.err));
      chk({tag, "_waits"}, 32'(waits), 32'(ws_of(d)));
      if (w && ok) mem[d][a[5:2]] = wd;
    end
  endtask

  task automatic idle(input int d, input string tag);
    @(negedge PCLK);
    psel[d] = 1'b0; pen[d] = 1'b0;
    chk({tag, "_rdy_low"}, 32'(pready[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 0; pen[d] = 0; pwr[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end
    clear_model();
    repeat (3) @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      chk("rst_prdata", prdata[d], 32'd0);
      chk("rst_pready", 32'(pready[d]), 32'd0);
      chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
    end
    PRESET = 1'b0;

    xfer(0, 32'h04, 1'b1, 32'hDEAD_BEEF, "ws1_wr04");
    xfer(0, 32'h04, 1'b0, 32'h0, "ws1_rd04");
    idle(0, "ws1");

    xfer(1, 32'h00, 1'b1, 32'h11, "ws0_wr00");
    xfer(1, 32'h3C, 1'b1, 32'h22, "ws0_wr3c");
    xfer(1, 32'h00, 1'b0, 32'h0, "ws0_rd00");
    xfer(1, 32'h3C, 1'b0, 32'h0, "ws0_rd3c");
    xfer(1, 32'h04, 1'b1, 32'h77, "ws0_wr04");
    xfer(1, 32'h40, 1'b1, 32'h99, "bad_wr40");
    xfer(1, 32'h06, 1'b0, 32'h0, "bad_rd06");
    xfer(1, 32'h00, 1'b0, 32'h0, "post_rd00");
    xfer(1, 32'h04, 1'b0, 32'h0, "post_rd04");
    idle(1, "ws0");

    xfer(2, 32'h08, 1'b1, 32'h5555, "ws3_wr08");
    idle(2, "ws3");
    setup(2, 32'h08, 1'b1, 32'hCAFE);
    chk("abort_acc1", 32'(pready[2]), 32'd0);
    @(negedge PCLK);
    chk("abort_acc2", 32'(pready[2]), 32'd0);
    psel[2] = 1'b0; pen[2] = 1'b0;
    @(negedge PCLK);
    chk("abort_idle", 32'(pready[2]), 32'd0);
    @(negedge PCLK);
    xfer(2, 32'h08, 1'b0, 32'h0, "abort_rd08");
    idle(2, "abort");

    setup(0, 32'h0C, 1'b1, 32'h1234);
    @(posedge PCLK);
    #2;
    chk("pre_rst_rdy", 32'(pready[0]), 32'd1);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_prdata", prdata[0], 32'd0);
    chk("mid_rst_pready", 32'(pready[0]), 32'd0);
    chk("mid_rst_pslverr", 32'(pslverr[0]), 32'd0);
    chk("mid_rst_prdata1", prdata[1], 32'd0);
    @(negedge PCLK);
    psel[0] = 1'b0; pen[0] = 1'b0;
    PRESET = 1'b0;
    clear_model();
    xfer(0, 32'h0C, 1'b0, 32'h0, "rst_rd0c");
    xfer(0, 32'h04, 1'b0, 32'h0, "rst_rd04");
    idle(0, "rst");
    xfer(2, 32'h08, 1'b0, 32'h0, "rst_rd08");
    idle(2, "rst2");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
